bounded_updown_counter: RTL

BOUNDED_UPDOWN_COUNTER -- requirements
Module: bounded_updown_counter

---
 rtl/counter_pkg.sv | 19 +
 rtl/counter_next_calc.sv | 145 ++++++++++++++
 rtl/bounded_updown_counter.sv | 117 +++++++++++
 3 files changed

// File: rtl/counter_pkg.sv
// ----------------------------------------------------------------------------
// counter_pkg
// Shared definitions for the bounded up/down counter.
//   counter_mode_t : counting behaviour selected by the 2-bit mode input
//     SAT    - clamp at the bound that was crossed
//     WRAP   - jump to the opposite bound, excess discarded
//     BOUNCE - reverse direction at a bound, direction held in a register
//     HOLD   - freeze count/dir (load still honoured)
// ----------------------------------------------------------------------------
package counter_pkg;

    typedef enum logic [1:0] {
        SAT    = 2'd0,
        WRAP   = 2'd1,
        BOUNCE = 2'd2,
        HOLD   = 2'd3
    } counter_mode_t;

endpackage : counter_pkg

// File: rtl/counter_next_calc.sv
// ----------------------------------------------------------------------------
// counter_next_calc
// Purely combinational next-value generator for bounded_updown_counter.
// Computes up/down candidates one bit wider than the count so that overflow
// and borrow are visible, range-checks them and applies the SAT / WRAP /
// BOUNCE selection. Also produces the clamped load value.
// Ports:
//   i_count      : current registered count
//   i_dir        : current registered direction (1 = up), used in BOUNCE
//   i_upDown     : requested direction for SAT/WRAP
//   i_mode       : counting mode
//   i_step       : unsigned step, zero-extended
//   i_minValue   : inclusive lower bound
//   i_maxValue   : inclusive upper bound
//   i_loadValue  : raw load value
//   o_next_count : count to take on an enabled step
//   o_next_dir   : direction to take on an enabled step
//   o_limit      : the step's first candidate was out of range
//   o_load_count : load value clamped into [min, max]
// ----------------------------------------------------------------------------
module counter_next_calc
    import counter_pkg::*;
#(
    parameter int Width     = 8,
    parameter int StepWidth = 4
) (
    input  logic [Width-1:0]     i_count,
    input  logic                 i_dir,
    input  logic                 i_upDown,
    input  counter_mode_t        i_mode,
    input  logic [StepWidth-1:0] i_step,
    input  logic [Width-1:0]     i_minValue,
    input  logic [Width-1:0]     i_maxValue,
    input  logic [Width-1:0]     i_loadValue,
    output logic [Width-1:0]     o_next_count,
    output logic                 o_next_dir,
    output logic                 o_limit,
    output logic [Width-1:0]     o_load_count
);

    // Clamp a widened value into [lo, hi]. A set top bit on a down result is
    // a borrow, i.e. the value went below zero, so it belongs at lo.
    function automatic logic [Width-1:0] saturate(
        input logic [Width:0]   v,
        input logic             is_down,
        input logic [Width-1:0] lo,
        input logic [Width-1:0] hi
    );
        logic [Width-1:0] res;
        if (is_down && v[Width]) begin
            res = lo;
        end else if (v > {1'b0, hi}) begin
            res = hi;
        end else if (v < {1'b0, lo}) begin
            res = lo;
        end else begin
            res = v[Width-1:0];
        end
        return res;
    endfunction

    logic [Width:0] w_step_ext;
    logic [Width:0] w_min_ext;
    logic [Width:0] w_max_ext;
    logic [Width:0] w_up_cand;
    logic [Width:0] w_dn_cand;
    logic           w_up_oor;
    logic           w_dn_oor;
    logic           w_step_zero;
    logic           w_go_up;

    assign w_step_ext  = {{(Width + 1 - StepWidth){1'b0}}, i_step};
    assign w_min_ext   = {1'b0, i_minValue};
    assign w_max_ext   = {1'b0, i_maxValue};
    assign w_up_cand   = {1'b0, i_count} + w_step_ext;
    assign w_dn_cand   = {1'b0, i_count} - w_step_ext;
    assign w_up_oor    = (w_up_cand > w_max_ext) || (w_up_cand < w_min_ext);
    assign w_dn_oor    = w_dn_cand[Width] || (w_dn_cand > w_max_ext) || (w_dn_cand < w_min_ext);
    assign w_step_zero = (i_step == {StepWidth{1'b0}});
    // BOUNCE follows the stored direction; the other modes follow upDown.
    assign w_go_up     = (i_mode == BOUNCE) ? i_dir : i_upDown;

    assign o_load_count = saturate({1'b0, i_loadValue}, 1'b0, i_minValue, i_maxValue);

    // Mode-dependent selection of next count, next direction and limit event.
    always_comb begin
        o_next_count = i_count;
        o_next_dir   = i_dir;
        o_limit      = 1'b0;
        if (w_step_zero) begin
            // A zero step never moves and never reports a limit, even when
            // the current count sits outside the bounds.
            o_next_count = i_count;
        end else begin
            case (i_mode)
                SAT: begin
                    if (w_go_up) begin
                        o_limit      = w_up_oor;
                        o_next_count = saturate(w_up_cand, 1'b0, i_minValue, i_maxValue);
                    end else begin
                        o_limit      = w_dn_oor;
                        o_next_count = saturate(w_dn_cand, 1'b1, i_minValue, i_maxValue);
                    end
                end
                WRAP: begin
                    if (w_go_up) begin
                        o_limit      = w_up_oor;
                        o_next_count = w_up_oor ? i_minValue : w_up_cand[Width-1:0];
                    end else begin
                        o_limit      = w_dn_oor;
                        o_next_count = w_dn_oor ? i_maxValue : w_dn_cand[Width-1:0];
                    end
                end
                BOUNCE: begin
                    if (w_go_up) begin
                        if (!w_up_oor) begin
                            o_next_count = w_up_cand[Width-1:0];
                        end else begin
                            // Reverse and step down in the same cycle; if the
                            // range is too narrow for that, park at max.
                            o_limit      = 1'b1;
                            o_next_dir   = 1'b0;
                            o_next_count = w_dn_oor ? i_maxValue : w_dn_cand[Width-1:0];
                        end
                    end else begin
                        if (!w_dn_oor) begin
                            o_next_count = w_dn_cand[Width-1:0];
                        end else begin
                            o_limit      = 1'b1;
                            o_next_dir   = 1'b1;
                            o_next_count = w_up_oor ? i_minValue : w_up_cand[Width-1:0];
                        end
                    end
                end
                HOLD: begin
                    o_next_count = i_count;
                end
                default: begin
                    o_next_count = i_count;
                end
            endcase
        end
    end

endmodule : counter_next_calc

// File: rtl/bounded_updown_counter.sv
// ----------------------------------------------------------------------------
// bounded_updown_counter
// Up/down counter constrained to [minValue, maxValue] with saturate, wrap,
// bounce and hold modes, a synchronous clamped load and a sticky
// configuration-error flag. Arithmetic lives in counter_next_calc; this level
// holds the registers, the load/step priority and the flags.
// Ports:
//   clk       : clock, rising edge
//   rst       : asynchronous active-high reset
//   en        : advance by one step this cycle
//   upDown    : 1 = up, 0 = down (SAT/WRAP); dir source on load
//   mode      : counter_mode_t (SAT/WRAP/BOUNCE/HOLD)
//   step      : unsigned step size
//   minValue  : inclusive lower bound
//   maxValue  : inclusive upper bound
//   load      : synchronous load request (beats en)
//   loadValue : value to load, clamped into bounds when bounds are valid
//   count     : registered count
//   dir       : registered direction (1 = up)
//   atMax     : count == maxValue (combinational)
//   atMin     : count == minValue (combinational)
//   limitHit  : one-cycle pulse after a step whose candidate left the range
//   cfgErr    : sticky, set while minValue > maxValue, cleared only by rst
// ----------------------------------------------------------------------------
module bounded_updown_counter
    import counter_pkg::*;
#(
    parameter int Width     = 8,
    parameter int StepWidth = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 upDown,
    input  logic [1:0]           mode,
    input  logic [StepWidth-1:0] step,
    input  logic [Width-1:0]     minValue,
    input  logic [Width-1:0]     maxValue,
    input  logic                 load,
    input  logic [Width-1:0]     loadValue,
    output logic [Width-1:0]     count,
    output logic                 dir,
    output logic                 atMax,
    output logic                 atMin,
    output logic                 limitHit,
    output logic                 cfgErr
);

    logic [Width-1:0] r_count;
    logic             r_dir;
    logic             r_limit_hit;
    logic             r_cfg_err;

    counter_mode_t    w_mode;
    logic             w_cfg_bad;
    logic             w_step_en;
    logic [Width-1:0] w_next_count;
    logic             w_next_dir;
    logic             w_limit;
    logic [Width-1:0] w_load_count;

    assign w_mode    = counter_mode_t'(mode);
    assign w_cfg_bad = (minValue > maxValue);
    // Steps are suppressed in HOLD and whenever the bounds are inverted.
    assign w_step_en = en && (w_mode != HOLD) && !w_cfg_bad;

    counter_next_calc #(
        .Width     (Width),
        .StepWidth (StepWidth)
    ) u_next_calc (
        .i_count      (r_count),
        .i_dir        (r_dir),
        .i_upDown     (upDown),
        .i_mode       (w_mode),
        .i_step       (step),
        .i_minValue   (minValue),
        .i_maxValue   (maxValue),
        .i_loadValue  (loadValue),
        .o_next_count (w_next_count),
        .o_next_dir   (w_next_dir),
        .o_limit      (w_limit),
        .o_load_count (w_load_count)
    );

    // Count, direction and flag registers with load > step > hold priority.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count     <= {Width{1'b0}};
            r_dir       <= 1'b1;
            r_limit_hit <= 1'b0;
            r_cfg_err   <= 1'b0;
        end else begin
            r_cfg_err <= r_cfg_err | w_cfg_bad;
            if (load) begin
                // With inverted bounds there is nothing sensible to clamp to,
                // so the raw value is taken.
                r_count     <= w_cfg_bad ? loadValue : w_load_count;
                r_dir       <= upDown;
                r_limit_hit <= 1'b0;
            end else if (w_step_en) begin
                r_count     <= w_next_count;
                r_dir       <= w_next_dir;
                r_limit_hit <= w_limit;
            end else begin
                r_limit_hit <= 1'b0;
            end
        end
    end

    assign count    = r_count;
    assign dir      = r_dir;
    assign limitHit = r_limit_hit;
    assign cfgErr   = r_cfg_err;
    assign atMax    = (r_count == maxValue);
    assign atMin    = (r_count == minValue);

endmodule : bounded_updown_counter
